addend_sequencer: RTL and testbench

- Upstream feeder for the 8-bit hybrid adder stage (ports a, b, sum, cout; no carry-in).
- Collects two NBYTES-wide operands as a byte stream over a valid/ready input, LSB first.
- Drives the adder one byte per cycle and folds in the inter-byte carry internally.
- Returns the multi-byte sum as a byte stream over a valid/ready output, plus a final carry.

---
 rtl/addend_sequencer.sv | 91 +++++++++
 tb/tb_addend_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/addend_sequencer.sv
// addend_sequencer: feeds an external 8-bit adder byte-serially to add two NBYTES-wide operands
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data operand byte stream, A bytes then B bytes, LSB first
//   adder_a/adder_b          operand bytes to the external adder (0 outside ADD)
//   adder_sum/adder_cout     combinational result of the external adder
//   out_valid/out_ready      result byte handshake
//   out_data/out_last        result byte (LSB first) and final-byte marker
//   out_carry                carry out of the full-width add, only with out_last
//   busy                     high while adding or emitting
module addend_sequencer #(
  parameter int NBYTES = 4,
  parameter int IDXW   = $clog2(NBYTES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] adder_a,
  output logic [7:0] adder_b,
  input  logic [7:0] adder_sum,
  input  logic       adder_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_carry,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, EMIT} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);
  state_t                r_state;
  logic [IDXW-1:0]       r_idx;
  logic                  r_c;
  logic [8*NBYTES-1:0]   r_a, r_b, r_r;
  int                    w_off;
  logic                  w_last;
  logic [IDXW-1:0]       w_nxt;
  assign w_off  = 8 * int'(r_idx);
  assign w_last = r_idx == LAST;
  assign w_nxt  = w_last ? '0 : r_idx + IDXW'(1);
  assign in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign busy      = (r_state == ADD) || (r_state == EMIT);
  assign adder_a   = (r_state == ADD) ? r_a[w_off +: 8] : 8'd0;
  assign adder_b   = (r_state == ADD) ? r_b[w_off +: 8] : 8'd0;
  assign out_valid = r_state == EMIT;
  assign out_data  = out_valid ? r_r[w_off +: 8] : 8'd0;
  assign out_last  = out_valid & w_last;
  assign out_carry = out_last & r_c;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_c     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
    end else begin
      case (r_state)
        IDLE: r_state <= LOAD_A;
        LOAD_A: if (in_valid) begin
          r_a[w_off +: 8] <= in_data;
          r_idx           <= w_nxt;
          if (w_last) r_state <= LOAD_B;
        end
        LOAD_B: if (in_valid) begin
          r_b[w_off +: 8] <= in_data;
          r_idx           <= w_nxt;
          if (w_last) begin
            r_c     <= 1'b0;
            r_state <= ADD;
          end
        end
        ADD: begin
          // the adder has no carry-in, so the running carry is added here;
          // a sum of FF plus an incoming carry wraps and carries onward
          r_r[w_off +: 8] <= adder_sum + {7'd0, r_c};
          r_c             <= adder_cout | ((adder_sum == 8'hFF) & r_c);
          r_idx           <= w_nxt;
          if (w_last) r_state <= EMIT;
        end
        EMIT: if (out_ready) begin
          r_idx <= w_nxt;
          if (w_last) r_state <= LOAD_A;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addend_sequencer.sv
// tb_addend_sequencer: scoreboard bench for addend_sequencer with a behavioural 8-bit adder
module tb_addend_sequencer;
  logic       clk = 0, rst = 1;
  logic       in_valid = 0, in_ready;
  logic [7:0] in_data = 0;
  logic [7:0] adder_a, adder_b, adder_sum;
  logic       adder_cout;
  logic       out_valid, out_ready = 1, out_last, out_carry, busy;
  logic [7:0] out_data;
  typedef struct packed {logic [7:0] d; logic last; logic carry;} exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0, n_pop = 0, cyc = 0, hs_cyc = 0;
  bit lat_armed = 0;
  addend_sequencer #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_carry(out_carry), .busy(busy)
  );
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (lat_armed && out_valid) begin
      check("latency", cyc - hs_cyc, 5);
      lat_armed = 0;
    end
    if (in_valid && busy) check("ready_busy", {31'd0, in_ready}, 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.d});
        check("out_last", {31'd0, out_last}, {31'd0, e.last});
        check("out_carry", {31'd0, out_carry}, {31'd0, e.carry});
      end
      n_pop++;
    end
  end
  task automatic send_byte(input logic [7:0] d, output int hcyc);
    bit done = 0;
    in_valid = 1;
    in_data  = d;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        hcyc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 1, 0);
    in_valid = 0;
  endtask
  task automatic send_ops(input logic [31:0] a, input logic [31:0] b, input bit gap);
    logic [32:0] s;
    int h;
    s = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < 4; i++) q.push_back({s[8*i +: 8], i == 3, (i == 3) & s[32]});
    for (int i = 0; i < 8; i++) begin
      send_byte(i < 4 ? a[8*i +: 8] : b[8*(i-4) +: 8], h);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
    hs_cyc = h;
    lat_armed = !gap;
  endtask
  task automatic drain();
    for (int k = 0; k < 300 && q.size() > 0; k++) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
    for (int k = 0; k < 50 && out_valid; k++) begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {out_valid, out_last, out_carry, busy, in_ready, out_data, adder_a, adder_b}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("ready_first", {31'd0, in_ready}, 0);
    @(negedge clk);
    check("ready_second", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    send_ops(32'h01020304, 32'h10203040, 0);
    drain();
    send_ops(32'hFFFFFFFF, 32'h00000001, 0);
    drain();
    send_ops(32'h80000000, 32'h80000000, 1);
    drain();
    out_ready = 0;
    send_ops(32'h01020304, 32'h10203040, 0);
    in_valid = 1;
    in_data  = 8'hAA;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(negedge clk);
      if (!out_valid) begin
        @(posedge clk); #1;
      end
    end
    check("bp_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check("bp_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h33});
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    send_ops(32'h01020304, 32'h10203040, 0);
    begin
      int base = n_pop;
      for (int k = 0; k < 50 && n_pop < base + 2; k++) @(posedge clk);
      #1;
    end
    rst = 1;
    #1;
    check("rst_async", {out_valid, out_last, out_carry, busy, out_data}, 0);
    q.delete();
    lat_armed = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) check("spurious_valid", 1, 0);
    end
    @(posedge clk); #1;
    send_ops(32'h01020304, 32'h10203040, 0);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
